// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the writeback request record for the register-file write-port arbiter.
package regfile_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between execute/memory writeback, the issue stage and the register-file write port.
// The fwd* signals exist only when REGARB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(parameter int N = 32);
  import regfile_ctrl_pkg::*;

  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [N-1:0]          req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [N-1:0]          req1_data;
  logic                  req1_ready;
  logic                  reserve_valid;
  logic [REG_ADDR_W-1:0] reserve_addr;
  logic [REG_ADDR_W-1:0] ReadRegister1;
  logic [REG_ADDR_W-1:0] ReadRegister2;
  logic                  busy1;
  logic                  busy2;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRegister;
  logic [N-1:0]          WriteData;
`ifdef REGARB_BYPASS_EN
  logic                  fwd1;
  logic [N-1:0]          fwd1_data;
  logic                  fwd2;
  logic [N-1:0]          fwd2_data;
`endif

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  reserve_valid, reserve_addr, ReadRegister1, ReadRegister2,
    output req0_ready, req1_ready, busy1, busy2,
`ifdef REGARB_BYPASS_EN
    output fwd1, fwd1_data, fwd2, fwd2_data,
`endif
    output RegWrite, WriteRegister, WriteData
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output reserve_valid, reserve_addr, ReadRegister1, ReadRegister2,
    input  req0_ready, req1_ready, busy1, busy2,
`ifdef REGARB_BYPASS_EN
    input  fwd1, fwd1_data, fwd2, fwd2_data,
`endif
    input  RegWrite, WriteRegister, WriteData
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer advances on an accepted grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_advance,
  output logic o_gnt0,
  output logic o_gnt1
);
  // Requester that wins the next tie; after a grant the other one is preferred.
  logic r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= o_gnt0;
    end
  end

  always_comb begin
    o_gnt0 = i_req0 && (!i_req1 || !r_ptr);
    o_gnt1 = i_req1 && (!i_req0 ||  r_ptr);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and multi-cycle writeback, with a pending scoreboard.
// Optional REGARB_BYPASS_EN adds same-cycle forwarding of the committing write to the read queries.
module regfile_wb_arbiter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  import regfile_ctrl_pkg::*;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  wb_req_t               w_sel;
  logic [NUM_REGS-1:0]   w_busy_nxt;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [N-1:0]          r_wdata;
  logic [NUM_REGS-1:0]   r_busy;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req0    (bus.req0_valid),
    .i_req1    (bus.req1_valid),
    .i_advance (w_accept),
    .o_gnt0    (w_gnt0),
    .o_gnt1    (w_gnt1)
  );

  assign w_accept       = w_gnt0 | w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  always_comb begin
    w_sel.addr = bus.req0_addr;
    w_sel.data = bus.req0_data;
    if (w_gnt1) begin
      w_sel.addr = bus.req1_addr;
      w_sel.data = bus.req1_data;
    end
  end

  // Writes to register 0 finish the handshake but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= ZERO_REG;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && (w_sel.addr != ZERO_REG);
      if (w_accept && (w_sel.addr != ZERO_REG)) begin
        r_waddr <= w_sel.addr;
        r_wdata <= w_sel.data;
      end
    end
  end

  assign bus.RegWrite      = r_we;
  assign bus.WriteRegister = r_waddr;
  assign bus.WriteData     = r_wdata;

  // A reservation landing on the same edge as a commit wins: it belongs to a newer instruction.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end
    if (bus.reserve_valid && (bus.reserve_addr != ZERO_REG)) begin
      w_busy_nxt[bus.reserve_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

`ifdef REGARB_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1        = r_we && (r_waddr != ZERO_REG) && (r_waddr == bus.ReadRegister1);
  assign w_fwd2        = r_we && (r_waddr != ZERO_REG) && (r_waddr == bus.ReadRegister2);
  assign bus.fwd1      = w_fwd1;
  assign bus.fwd2      = w_fwd2;
  assign bus.fwd1_data = r_wdata;
  assign bus.fwd2_data = r_wdata;
  assign bus.busy1     = r_busy[bus.ReadRegister1] & ~w_fwd1;
  assign bus.busy2     = r_busy[bus.ReadRegister2] & ~w_fwd2;
`else
  assign bus.busy1     = r_busy[bus.ReadRegister1];
  assign bus.busy2     = r_busy[bus.ReadRegister2];
`endif
endmodule
